// File: rtl/run_halt_monitor_if.sv
// Register-dump stream: one register index/value per valid&ready transfer.
interface run_halt_monitor_if #(
  parameter int DW   = 32,
  parameter int SELW = 5
);
  logic            dump_valid;
  logic            dump_ready;
  logic [SELW-1:0] dump_idx;
  logic [DW-1:0]   dump_data;

  modport master (output dump_valid, output dump_idx, output dump_data, input dump_ready);
  modport slave  (input dump_valid, input dump_idx, input dump_data, output dump_ready);
endinterface

// File: rtl/run_halt_monitor.sv
// Run-control monitor: freezes the CPU on PC hit / cycle budget / external stop (hold same cycle),
// then streams the register file one word per valid&ready; the word holds steady while the consumer stalls.
module run_halt_monitor #(
  parameter int            DW         = 32,
  parameter int            NREG       = 32,
  parameter logic [DW-1:0] HALT_PC    = 32'h00000048,
  parameter int            HIT_COUNT  = 1,
  parameter int            MAX_CYCLES = 1000,
  parameter int            CW         = 16,
  localparam int           SELW       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DW-1:0]        pc,
  input  logic [DW-1:0]        instr,
  input  logic                 stop_req,
  output logic [SELW-1:0]      reg_sel,
  input  logic [DW-1:0]        reg_data,
  output logic                 cpu_hold,
  output logic                 halted,
  output logic [1:0]           cause,
  output logic [CW-1:0]        cycles,
  output logic [DW-1:0]        halt_pc,
  output logic [DW-1:0]        halt_instr,
  run_halt_monitor_if.master   dump,
  output logic                 done
);

  localparam int HW = (HIT_COUNT > 1) ? $clog2(HIT_COUNT) : 1;

  typedef enum logic [1:0] {RUN, DUMP, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cyc_q;
  logic [HW-1:0]   hits_q;
  logic [SELW-1:0] idx_q;
  logic            pc_hit, last_hit, timeout, halt_now;

  assign pc_hit   = (pc == HALT_PC);
  assign last_hit = pc_hit && (hits_q == HW'(HIT_COUNT - 1));
  assign timeout  = (MAX_CYCLES != 0) && (cyc_q == CW'(MAX_CYCLES));

  always_comb begin
    state_nxt = state;
    halt_now  = 1'b0;
    case (state)
      RUN: begin
        halt_now = last_hit || timeout || stop_req;
        if (halt_now) state_nxt = DUMP;
      end
      DUMP: begin
        if (dump.dump_ready && (idx_q == SELW'(NREG - 1))) state_nxt = DONE;
      end
      default: state_nxt = DONE;
    endcase
  end

  // Holding in the halt cycle itself keeps the matching instruction from committing.
  assign cpu_hold        = halt_now || (state != RUN);
  assign reg_sel         = (state == DUMP) ? idx_q : '0;
  assign dump.dump_valid = (state == DUMP);
  assign dump.dump_idx   = (state == DUMP) ? idx_q : '0;
  assign dump.dump_data  = (state == DUMP) ? reg_data : '0;
  assign done            = (state == DONE);
  assign cycles          = cyc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RUN;
      cyc_q      <= '0;
      hits_q     <= '0;
      idx_q      <= '0;
      halted     <= 1'b0;
      cause      <= 2'd0;
      halt_pc    <= '0;
      halt_instr <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN) begin
        if (halt_now) begin
          halted     <= 1'b1;
          halt_pc    <= pc;
          halt_instr <= instr;
          idx_q      <= '0;
          // PC match outranks timeout, which outranks the external stop.
          cause      <= last_hit ? 2'd1 : (timeout ? 2'd2 : 2'd3);
        end else begin
          if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
          if (pc_hit && (hits_q != HW'(HIT_COUNT - 1))) hits_q <= hits_q + 1'b1;
        end
      end else if ((state == DUMP) && dump.dump_ready) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_run_halt_monitor.sv
// Three monitor configurations driven by shared stimulus, checked each cycle against a behavioural model.
module tb_run_halt_monitor;
  localparam logic [31:0] HPC  = 32'h48;
  localparam int          NREG = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc = '0, instr = '0, salt = '0;
  logic        stop_req = 1'b0, rdy = 1'b0;

  logic [4:0]  reg_sel [3];
  logic [31:0] reg_data [3];
  logic        cpu_hold [3], halted [3], done [3];
  logic [1:0]  cause [3];
  logic [31:0] halt_pc [3], halt_instr [3];
  logic [15:0] cyc0;
  logic [7:0]  cyc1;
  logic [3:0]  cyc2;
  logic        dv [3];
  logic [4:0]  didx [3];
  logic [31:0] ddat [3];

  int n_cmp = 0, n_bad = 0, xfers0 = 0;

  run_halt_monitor_if #(.DW(32), .SELW(5)) dif0 ();
  run_halt_monitor_if #(.DW(32), .SELW(5)) dif1 ();
  run_halt_monitor_if #(.DW(32), .SELW(5)) dif2 ();

  assign dif0.dump_ready = rdy;
  assign dif1.dump_ready = rdy;
  assign dif2.dump_ready = rdy;
  assign dv[0] = dif0.dump_valid;  assign didx[0] = dif0.dump_idx;  assign ddat[0] = dif0.dump_data;
  assign dv[1] = dif1.dump_valid;  assign didx[1] = dif1.dump_idx;  assign ddat[1] = dif1.dump_data;
  assign dv[2] = dif2.dump_valid;  assign didx[2] = dif2.dump_idx;  assign ddat[2] = dif2.dump_data;

  for (genvar g = 0; g < 3; g++) begin : g_rf
    assign reg_data[g] = {27'b0, reg_sel[g]} * 32'd3 + salt;
  end

  run_halt_monitor #(.DW(32), .NREG(NREG), .HALT_PC(HPC), .HIT_COUNT(1), .MAX_CYCLES(1000), .CW(16)) u0 (
    .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .stop_req(stop_req),
    .reg_sel(reg_sel[0]), .reg_data(reg_data[0]), .cpu_hold(cpu_hold[0]), .halted(halted[0]),
    .cause(cause[0]), .cycles(cyc0), .halt_pc(halt_pc[0]), .halt_instr(halt_instr[0]),
    .dump(dif0), .done(done[0]));

  run_halt_monitor #(.DW(32), .NREG(NREG), .HALT_PC(HPC), .HIT_COUNT(2), .MAX_CYCLES(10), .CW(8)) u1 (
    .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .stop_req(stop_req),
    .reg_sel(reg_sel[1]), .reg_data(reg_data[1]), .cpu_hold(cpu_hold[1]), .halted(halted[1]),
    .cause(cause[1]), .cycles(cyc1), .halt_pc(halt_pc[1]), .halt_instr(halt_instr[1]),
    .dump(dif1), .done(done[1]));

  run_halt_monitor #(.DW(32), .NREG(NREG), .HALT_PC(HPC), .HIT_COUNT(3), .MAX_CYCLES(0), .CW(4)) u2 (
    .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .stop_req(stop_req),
    .reg_sel(reg_sel[2]), .reg_data(reg_data[2]), .cpu_hold(cpu_hold[2]), .halted(halted[2]),
    .cause(cause[2]), .cycles(cyc2), .halt_pc(halt_pc[2]), .halt_instr(halt_instr[2]),
    .dump(dif2), .done(done[2]));

  always #5 clk = ~clk;

  // Per-instance configuration and model state.
  int          P_HIT [3]  = '{1, 2, 3};
  int          P_MAX [3]  = '{1000, 10, 0};
  int          P_CMAX [3] = '{65535, 255, 15};
  int          m_cyc [3], m_hits [3], m_sent [3], m_cause [3];
  bit          m_halted [3];
  logic [31:0] m_hpc [3], m_hin [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int act_cyc(input int i);
    case (i)
      0:       return int'(cyc0);
      1:       return int'(cyc1);
      default: return int'(cyc2);
    endcase
  endfunction

  // Model + compare: sample at the falling edge, then predict the next rising edge.
  initial begin
    bit last, tmo, hn, vld;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rstn) begin
          m_cyc[i] = 0; m_hits[i] = 0; m_sent[i] = 0; m_cause[i] = 0;
          m_halted[i] = 1'b0; m_hpc[i] = '0; m_hin[i] = '0;
        end
        last = (pc == HPC) && (m_hits[i] == P_HIT[i] - 1);
        tmo  = (P_MAX[i] != 0) && (m_cyc[i] == P_MAX[i]);
        hn   = !m_halted[i] && (last || tmo || stop_req);
        vld  = m_halted[i] && (m_sent[i] < NREG);
        chk($sformatf("u%0d.cpu_hold", i), 32'(cpu_hold[i]), 32'(hn || m_halted[i]));
        chk($sformatf("u%0d.halted", i), 32'(halted[i]), 32'(m_halted[i]));
        chk($sformatf("u%0d.cause", i), 32'(cause[i]), m_cause[i]);
        chk($sformatf("u%0d.cycles", i), act_cyc(i), m_cyc[i]);
        chk($sformatf("u%0d.halt_pc", i), halt_pc[i], m_hpc[i]);
        chk($sformatf("u%0d.halt_instr", i), halt_instr[i], m_hin[i]);
        chk($sformatf("u%0d.dump_valid", i), 32'(dv[i]), 32'(vld));
        chk($sformatf("u%0d.dump_idx", i), 32'(didx[i]), vld ? m_sent[i] : 0);
        chk($sformatf("u%0d.reg_sel", i), 32'(reg_sel[i]), vld ? m_sent[i] : 0);
        chk($sformatf("u%0d.dump_data", i), ddat[i], vld ? (m_sent[i] * 3 + salt) : 32'd0);
        chk($sformatf("u%0d.done", i), 32'(done[i]), 32'(m_halted[i] && (m_sent[i] == NREG)));
        if (rstn) begin
          if (i == 0 && vld && rdy) xfers0++;
          if (!m_halted[i]) begin
            if (hn) begin
              m_halted[i] = 1'b1; m_hpc[i] = pc; m_hin[i] = instr; m_sent[i] = 0;
              m_cause[i] = last ? 1 : (tmo ? 2 : 3);
            end else begin
              if (m_cyc[i] < P_CMAX[i]) m_cyc[i]++;
              if (pc == HPC && m_hits[i] < P_HIT[i] - 1) m_hits[i]++;
            end
          end else if (vld && rdy) begin
            m_sent[i]++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset state pins
    #2;
    chk("rst.halted", 32'(halted[0]), 32'd0);
    chk("rst.dump_valid", 32'(dv[0]), 32'd0);
    chk("rst.cpu_hold", 32'(cpu_hold[0]), 32'd0);
    step(); step();
    rstn = 1'b1;
    xfers0 = 0;

    // Phase 1: pc climbs by 4 to 0x48, then loops 0x40/0x44/0x48; ready toggles.
    for (int k = 0; k < 150; k++) begin
      pc    = (k <= 18) ? 32'(4 * k) : 32'(32'h40 + 4 * ((k - 19) % 3));
      instr = $urandom;
      rdy   = k[0];
      #1;
      if (k == 18) begin
        chk("p1.u0_hold_at_48", 32'(cpu_hold[0]), 32'd1);
        chk("p1.u0_not_yet_halted", 32'(halted[0]), 32'd0);
        chk("p1.u2_first_visit_runs", 32'(cpu_hold[2]), 32'd0);
      end
      if (k == 21) chk("p1.u2_second_visit_runs", 32'(cpu_hold[2]), 32'd0);
      if (k == 24) chk("p1.u2_third_visit_holds", 32'(cpu_hold[2]), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("p1.u0_cause", 32'(cause[0]), 32'd1);
    chk("p1.u0_halt_pc", halt_pc[0], 32'h48);
    chk("p1.u0_cycles", 32'(cyc0), 32'd18);
    chk("p1.u1_cause", 32'(cause[1]), 32'd2);
    chk("p1.u1_cycles", 32'(cyc1), 32'd10);
    chk("p1.u1_halt_pc", halt_pc[1], 32'h28);
    chk("p1.u2_cause", 32'(cause[2]), 32'd1);
    chk("p1.u2_cycles_sat", 32'(cyc2), 32'd15);
    chk("p1.u0_xfers", xfers0, NREG);
    chk("p1.u0_done", 32'(done[0]), 32'd1);
    chk("p1.u2_done", 32'(done[2]), 32'd1);

    // Phase 2: stop and PC match together, then reset mid-dump at index 5.
    rstn = 1'b0; step(); rstn = 1'b1;
    pc = 32'h48; stop_req = 1'b1; rdy = 1'b0;
    step();
    stop_req = 1'b0; pc = '0;
    chk("p2.u0_cause_pc_wins", 32'(cause[0]), 32'd1);
    chk("p2.u1_cause_stop", 32'(cause[1]), 32'd3);
    chk("p2.u2_cause_stop", 32'(cause[2]), 32'd3);
    n = 0;
    while (n < 200 && !(dv[0] && didx[0] == 5'd5)) begin
      rdy = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("p2.reached_idx5", 32'(n < 200), 32'd1);
    rstn = 1'b0;
    #1;
    chk("p2.rst_halted", 32'(halted[0]), 32'd0);
    chk("p2.rst_valid", 32'(dv[0]), 32'd0);
    chk("p2.rst_idx", 32'(didx[0]), 32'd0);
    chk("p2.rst_done", 32'(done[0]), 32'd0);
    chk("p2.rst_cause", 32'(cause[0]), 32'd0);
    chk("p2.rst_hold", 32'(cpu_hold[0]), 32'd0);
    step();
    rstn = 1'b1;
    step(); step(); step();
    chk("p2.restart_cycles", 32'(cyc0), 32'd3);

    // Phase 3: randomized episodes with sporadic stops and reset blips.
    for (int e = 0; e < 20; e++) begin
      rstn = 1'b0; salt = $urandom; step(); rstn = 1'b1;
      for (int k = 0; k < 150; k++) begin
        case ($urandom_range(0, 3))
          0:       pc = 32'h48;
          1:       pc = 32'h44;
          2:       pc = 32'h40;
          default: pc = 32'($urandom_range(0, 255) * 4);
        endcase
        instr    = $urandom;
        stop_req = ($urandom_range(0, 39) == 0);
        rdy      = 1'($urandom_range(0, 1));
        rstn     = ($urandom_range(0, 299) != 0);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
